// File: rtl/iir_biquad_df1_pkg.sv
// Shared types for the DF-I biquad: filter-type values common with the coefficient
// model, plus the controller state and coefficient-slot enums.
package iir_biquad_types_pkg;
    typedef enum logic [2:0] {
        FT_LOWPASS,
        FT_HIGHPASS,
        FT_BANDPASS,
        FT_NOTCH,
        FT_ALLPASS
    } filter_type_e;
endpackage

package iir_biquad_df1_pkg;
    import iir_biquad_types_pkg::*;

    typedef filter_type_e biquad_type_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_MAC,
        ST_OUT
    } state_e;

    // Order of the enum is the order the shared multiplier walks the taps.
    typedef enum logic [2:0] {
        CI_B0,
        CI_B1,
        CI_B2,
        CI_A1,
        CI_A2
    } coef_idx_t;
endpackage

// File: rtl/iir_sat_shift.sv
// Arithmetic right shift (truncating) of a wide signed value, then clamp to a
// narrower signed range with a flag when clamping happened.
module iir_sat_shift #(
    parameter int IN_W_P  = 64,
    parameter int OUT_W_P = 32,
    parameter int SHIFT_P = 15
) (
    input  logic signed [IN_W_P-1:0]  data_i,
    output logic signed [OUT_W_P-1:0] data_o,
    output logic                      sat_o
);
    logic signed [IN_W_P-1:0]    shifted;
    logic [IN_W_P-OUT_W_P:0]     top_bits;

    assign shifted  = data_i >>> SHIFT_P;
    assign top_bits = shifted[IN_W_P-1:OUT_W_P-1];

    // In range only when every bit above the output sign bit repeats it.
    always_comb begin
        sat_o  = 1'b0;
        data_o = shifted[OUT_W_P-1:0];
        if (!((&top_bits) || !(|top_bits))) begin
            sat_o  = 1'b1;
            data_o = shifted[IN_W_P-1] ? {1'b1, {(OUT_W_P-1){1'b0}}}
                                       : {1'b0, {(OUT_W_P-1){1'b1}}};
        end
    end
endmodule

// File: rtl/iir_biquad_df1.sv
// Direct Form I biquad with a single time-shared multiplier: one sample in,
// five MAC cycles (b0,b1,b2,a1,a2), one registered output held until accepted.
module iir_biquad_df1
    import iir_biquad_df1_pkg::*;
#(
    parameter int N_BITS_P = 32,
    parameter int Q_BITS_P = 15
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       x_valid,
    output logic                       x_ready,
    input  logic signed [N_BITS_P-1:0] x_data,
    output logic                       y_valid,
    input  logic                       y_ready,
    output logic signed [N_BITS_P-1:0] y_data,
    input  logic signed [N_BITS_P-1:0] cr_b0,
    input  logic signed [N_BITS_P-1:0] cr_b1,
    input  logic signed [N_BITS_P-1:0] cr_b2,
    input  logic signed [N_BITS_P-1:0] cr_a1,
    input  logic signed [N_BITS_P-1:0] cr_a2,
    input  logic                       cr_coef_update,
    input  logic                       cr_clear,
    output logic                       sr_overflow
);
    localparam int ACC_W = 2 * N_BITS_P;

    state_e                     state_q;
    coef_idx_t                  idx_q;
    logic                       x_ready_q, y_valid_q, ovf_q, upd_pend_q, clr_pend_q;
    logic signed [N_BITS_P-1:0] b0_q, b1_q, b2_q, a1_q, a2_q;
    logic signed [N_BITS_P-1:0] x0_q, x1_q, x2_q, y1_q, y2_q, y_data_q;
    logic signed [ACC_W-1:0]    acc_q, acc_d, prod_d;
    logic signed [N_BITS_P-1:0] coef_d, opnd_d, sat_data_d;
    logic                       sat_flag_d, upd_now, clr_now;

    assign upd_now = cr_coef_update || upd_pend_q;
    assign clr_now = cr_clear || clr_pend_q;

    // Operand select and accumulate; feedback taps subtract.
    always_comb begin
        coef_d = b0_q;
        opnd_d = x0_q;
        case (idx_q)
            CI_B1:   begin coef_d = b1_q; opnd_d = x1_q; end
            CI_B2:   begin coef_d = b2_q; opnd_d = x2_q; end
            CI_A1:   begin coef_d = a1_q; opnd_d = y1_q; end
            CI_A2:   begin coef_d = a2_q; opnd_d = y2_q; end
            default: begin coef_d = b0_q; opnd_d = x0_q; end
        endcase
        prod_d = ACC_W'(coef_d) * ACC_W'(opnd_d);
        acc_d  = (idx_q == CI_A1 || idx_q == CI_A2) ? acc_q - prod_d : acc_q + prod_d;
    end

    iir_sat_shift #(
        .IN_W_P (ACC_W),
        .OUT_W_P(N_BITS_P),
        .SHIFT_P(Q_BITS_P)
    ) u_sat (
        .data_i(acc_d),
        .data_o(sat_data_d),
        .sat_o (sat_flag_d)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            idx_q      <= CI_B0;
            x_ready_q  <= 1'b0;
            y_valid_q  <= 1'b0;
            y_data_q   <= '0;
            ovf_q      <= 1'b0;
            upd_pend_q <= 1'b0;
            clr_pend_q <= 1'b0;
            acc_q      <= '0;
            {b0_q, b1_q, b2_q, a1_q, a2_q} <= '0;
            {x0_q, x1_q, x2_q, y1_q, y2_q} <= '0;
        end else begin
            if (cr_coef_update) upd_pend_q <= 1'b1;
            if (cr_clear)       clr_pend_q <= 1'b1;
            case (state_q)
                ST_IDLE: begin
                    // Loads and clears land before a coincident sample starts MAC.
                    if (upd_now) begin
                        b0_q <= cr_b0;
                        b1_q <= cr_b1;
                        b2_q <= cr_b2;
                        a1_q <= cr_a1;
                        a2_q <= cr_a2;
                        upd_pend_q <= 1'b0;
                    end
                    if (clr_now) begin
                        {x1_q, x2_q, y1_q, y2_q} <= '0;
                        ovf_q      <= 1'b0;
                        clr_pend_q <= 1'b0;
                    end
                    if (x_valid && x_ready_q) begin
                        x0_q      <= x_data;
                        acc_q     <= '0;
                        idx_q     <= CI_B0;
                        x_ready_q <= 1'b0;
                        state_q   <= ST_MAC;
                    end else begin
                        x_ready_q <= 1'b1;
                    end
                end
                ST_MAC: begin
                    acc_q <= acc_d;
                    if (idx_q == CI_A2) begin
                        y_data_q  <= sat_data_d;
                        y_valid_q <= 1'b1;
                        if (sat_flag_d) ovf_q <= 1'b1;
                        state_q   <= ST_OUT;
                    end else begin
                        idx_q <= coef_idx_t'(idx_q + 3'd1);
                    end
                end
                ST_OUT: begin
                    if (y_ready) begin
                        x2_q      <= x1_q;
                        x1_q      <= x0_q;
                        y2_q      <= y1_q;
                        y1_q      <= y_data_q;
                        y_valid_q <= 1'b0;
                        x_ready_q <= 1'b1;
                        state_q   <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign x_ready     = x_ready_q;
    assign y_valid     = y_valid_q;
    assign y_data      = y_data_q;
    assign sr_overflow = ovf_q;
endmodule

// File: tb/tb_iir_biquad_df1.sv
// Directed bench for iir_biquad_df1: expected outputs queued at input time and
// compared when the filter presents each result.
module tb_iir_biquad_df1;
    logic               clk = 1'b0;
    logic               rst_n;
    logic               x_valid, x_ready, y_valid, y_ready;
    logic signed [31:0] x_data, y_data;
    logic signed [31:0] cr_b0, cr_b1, cr_b2, cr_a1, cr_a2;
    logic               cr_coef_update, cr_clear, sr_overflow;

    int checks = 0;
    int errors = 0;
    logic signed [31:0] exp_q[$];

    iir_biquad_df1 #(.N_BITS_P(32), .Q_BITS_P(15)) dut (
        .clk(clk), .rst_n(rst_n),
        .x_valid(x_valid), .x_ready(x_ready), .x_data(x_data),
        .y_valid(y_valid), .y_ready(y_ready), .y_data(y_data),
        .cr_b0(cr_b0), .cr_b1(cr_b1), .cr_b2(cr_b2), .cr_a1(cr_a1), .cr_a2(cr_a2),
        .cr_coef_update(cr_coef_update), .cr_clear(cr_clear),
        .sr_overflow(sr_overflow)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic signed [63:0] obs,
                         input logic signed [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    task automatic load_coefs(input int b0, input int b1, input int b2,
                              input int a1, input int a2, input logic clr);
        cr_b0 = b0; cr_b1 = b1; cr_b2 = b2; cr_a1 = a1; cr_a2 = a2;
        cr_coef_update = 1'b1;
        cr_clear = clr;
        tick();
        cr_coef_update = 1'b0;
        cr_clear = 1'b0;
    endtask

    task automatic send_x(input logic signed [31:0] x, input logic upd);
        int w = 0;
        x_data = x;
        x_valid = 1'b1;
        while (!x_ready && w < 20) begin tick(); w++; end
        if (!x_ready) check("x_ready_timeout", 0, 1);
        cr_coef_update = upd;
        tick();
        x_valid = 1'b0;
        cr_coef_update = 1'b0;
    endtask

    task automatic wait_y(input string tag);
        int n = 0;
        while (!y_valid && n < 20) begin tick(); n++; end
        check({tag, "_latency"}, n, 5);
    endtask

    task automatic take_y(input string tag);
        logic signed [31:0] e;
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'sd0;
        check({tag, "_y"}, y_data, e);
        y_ready = 1'b1;
        tick();
        y_ready = 1'b0;
        check({tag, "_yvalid_drop"}, y_valid, 0);
    endtask

    task automatic do_sample(input string tag, input logic signed [31:0] x,
                             input logic signed [31:0] e, input logic upd);
        exp_q.push_back(e);
        send_x(x, upd);
        wait_y(tag);
        take_y(tag);
    endtask

    initial begin
        rst_n = 1'b0; x_valid = 1'b0; y_ready = 1'b0; x_data = '0;
        cr_b0 = '0; cr_b1 = '0; cr_b2 = '0; cr_a1 = '0; cr_a2 = '0;
        cr_coef_update = 1'b0; cr_clear = 1'b0;
        repeat (3) tick();
        check("rst_x_ready", x_ready, 0);
        check("rst_y_valid", y_valid, 0);
        check("rst_y_data", y_data, 0);
        check("rst_overflow", sr_overflow, 0);
        rst_n = 1'b1;
        tick();
        check("rel_x_ready", x_ready, 1);

        // Identity
        load_coefs(32768, 0, 0, 0, 0, 1'b1);
        do_sample("ident_pos", 1000, 1000, 1'b0);
        do_sample("ident_neg", -1234, -1234, 1'b0);

        // FIR tap
        load_coefs(32768, 16384, 0, 0, 0, 1'b1);
        do_sample("fir0", 32768, 32768, 1'b0);
        do_sample("fir1", 0, 16384, 1'b0);
        do_sample("fir2", 0, 0, 1'b0);
        do_sample("fir3", 0, 0, 1'b0);

        // Feedback
        load_coefs(32768, 0, 0, -16384, 0, 1'b1);
        do_sample("fb0", 32768, 32768, 1'b0);
        do_sample("fb1", 0, 16384, 1'b0);
        do_sample("fb2", 0, 8192, 1'b0);
        do_sample("fb3", 0, 4096, 1'b0);

        // Saturation, both rails
        load_coefs(32768, 32768, 0, 0, 0, 1'b1);
        do_sample("satp0", 32'sh7FFF_FFFF, 32'sh7FFF_FFFF, 1'b0);
        check("satp0_ovf", sr_overflow, 0);
        do_sample("satp1", 32'sh7FFF_FFFF, 32'sh7FFF_FFFF, 1'b0);
        check("satp1_ovf", sr_overflow, 1);
        cr_clear = 1'b1; tick(); cr_clear = 1'b0;
        check("satp_clear_ovf", sr_overflow, 0);
        do_sample("satn0", 32'sh8000_0000, 32'sh8000_0000, 1'b0);
        check("satn0_ovf", sr_overflow, 0);
        do_sample("satn1", 32'sh8000_0000, 32'sh8000_0000, 1'b0);
        check("satn1_ovf", sr_overflow, 1);
        cr_clear = 1'b1; tick(); cr_clear = 1'b0;
        check("satn_clear_ovf", sr_overflow, 0);

        // Update coincident with the input handshake uses the new set
        cr_b0 = 98304; cr_b1 = 0;
        do_sample("upd_coincident", 100, 300, 1'b1);

        // Backpressure with an update requested during OUT
        load_coefs(32768, 0, 0, 0, 0, 1'b1);
        exp_q.push_back(500);
        send_x(500, 1'b0);
        wait_y("bp");
        cr_b0 = 65536;
        cr_coef_update = 1'b1; tick(); cr_coef_update = 1'b0;
        for (int i = 0; i < 10; i++) begin
            check("bp_hold_y", y_data, 500);
            check("bp_hold_valid", y_valid, 1);
            check("bp_hold_x_ready", x_ready, 0);
            tick();
        end
        take_y("bp");
        do_sample("bp_newset", 500, 1000, 1'b0);

        // Reset mid-MAC aborts the sample and zeroes history
        load_coefs(32768, 32768, 0, 0, 0, 1'b1);
        do_sample("pre_rst", 1000, 1000, 1'b0);
        send_x(50, 1'b0);
        tick(); tick();
        rst_n = 1'b0;
        tick();
        check("midrst_x_ready", x_ready, 0);
        check("midrst_y_valid", y_valid, 0);
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("midrst_no_output", y_valid, 0);
        end
        load_coefs(32768, 32768, 0, 0, 0, 1'b0);
        do_sample("post_rst_zero_hist", 200, 200, 1'b0);

        check("scoreboard_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
